// File: rtl/alarm_tone_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_tone_sequencer
//
// Purpose:
//   Produces the alarm beep stream for the audio output path: a gated square
//   wave made of tone bursts separated by silence. One stereo sample pair is
//   written into the audio controller each time it reports FIFO space. The
//   controller FIFO is cleared once when the alarm starts and once more when it
//   stops, so the speaker falls silent at once.
//
// Ports:
//   CLOCK_50                 in   1   system clock, rising-edge
//   reset                    in   1   asynchronous, active-high
//   alarm_on                 in   1   level: 1 = sound alarm, 0 = silence
//   volume                   in   2   0 = quietest .. 3 = full scale
//   audio_out_allowed        in   1   controller reports FIFO space
//   left_channel_audio_out   out  32  sample to the controller, left
//   right_channel_audio_out  out  32  sample to the controller, right (= left)
//   write_audio_out          out  1   one-cycle write strobe
//   clear_audio_out_memory   out  1   one-cycle FIFO-clear pulse
//   busy                     out  1   1 whenever the sequencer is not idle
//   beep_count               out  8   completed bursts since start, saturating
// -----------------------------------------------------------------------------
module alarm_tone_sequencer #(
    parameter int          HALF_PERIOD = 48,
    parameter int          BEEP_ON     = 24000,
    parameter int          BEEP_OFF    = 24000,
    parameter logic [31:0] AMPLITUDE   = 32'h10000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        alarm_on,
    input  logic [1:0]  volume,
    input  logic        audio_out_allowed,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        write_audio_out,
    output logic        clear_audio_out_memory,
    output logic        busy,
    output logic [7:0]  beep_count
);

    localparam int HW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PMAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] HALF_ONE  = HW'(1);
    localparam logic [PW-1:0] ON_LAST   = PW'(BEEP_ON - 1);
    localparam logic [PW-1:0] OFF_LAST  = PW'(BEEP_OFF - 1);
    localparam logic [PW-1:0] PHASE_ONE = PW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [HW-1:0]   half_cnt;
    logic [PW-1:0]   phase_cnt;
    logic            polarity;
    logic            on_phase;
    logic [31:0]     sample;

    // Square-wave sample for the current counter state; silence in the off
    // phase. The negative peak is the two's complement of the scaled peak.
    function automatic logic [31:0] tone_sample(input logic       on,
                                                input logic       pol,
                                                input logic [1:0] vol);
        logic [31:0] amp;
        amp = AMPLITUDE >> (2'd3 - vol);
        if (!on) begin
            tone_sample = 32'd0;
        end else if (pol) begin
            tone_sample = ~amp + 32'd1;
        end else begin
            tone_sample = amp;
        end
    endfunction

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a dropped alarm_on wins over FIFO space in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (alarm_on) next_state = CLEAR;
                else          next_state = IDLE;
            end
            CLEAR: next_state = WAIT;
            WAIT: begin
                if (!alarm_on)              next_state = STOP;
                else if (audio_out_allowed) next_state = WRITE;
                else                        next_state = WAIT;
            end
            WRITE:   next_state = WAIT;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes and busy are decoded from next_state so the registered outputs
    // line up with the state they describe.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            write_audio_out        <= 1'b0;
            clear_audio_out_memory <= 1'b0;
            busy                   <= 1'b0;
        end else begin
            write_audio_out        <= (next_state == WRITE);
            clear_audio_out_memory <= (next_state == CLEAR) || (next_state == STOP);
            busy                   <= (next_state != IDLE);
        end
    end

    // Sample register: loaded on the way into WRITE, held until the next
    // write, and forced to zero when idle or once the burst ends.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sample <= 32'd0;
        end else if (next_state == WRITE) begin
            sample <= tone_sample(on_phase, polarity, volume);
        end else if ((next_state == IDLE) || (next_state == CLEAR)) begin
            sample <= 32'd0;
        end else if ((state == WRITE) && on_phase && (phase_cnt == ON_LAST)) begin
            sample <= 32'd0;
        end else begin
            sample <= sample;
        end
    end

    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

    // Tone and burst counters: zeroed on start, advanced once per write.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            half_cnt   <= '0;
            phase_cnt  <= '0;
            polarity   <= 1'b0;
            on_phase   <= 1'b0;
            beep_count <= 8'd0;
        end else if ((state == IDLE) && (next_state == CLEAR)) begin
            half_cnt   <= '0;
            phase_cnt  <= '0;
            polarity   <= 1'b0;
            on_phase   <= 1'b1;
            beep_count <= 8'd0;
        end else if (state == WRITE) begin
            if (on_phase) begin
                if (phase_cnt == ON_LAST) begin
                    // Burst finished: next burst must start on the positive half.
                    phase_cnt <= '0;
                    on_phase  <= 1'b0;
                    half_cnt  <= '0;
                    polarity  <= 1'b0;
                    if (beep_count != 8'hFF) begin
                        beep_count <= beep_count + 8'd1;
                    end else begin
                        beep_count <= beep_count;
                    end
                end else begin
                    phase_cnt <= phase_cnt + PHASE_ONE;
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        polarity <= ~polarity;
                    end else begin
                        half_cnt <= half_cnt + HALF_ONE;
                    end
                end
            end else begin
                if (phase_cnt == OFF_LAST) begin
                    phase_cnt <= '0;
                    on_phase  <= 1'b1;
                end else begin
                    phase_cnt <= phase_cnt + PHASE_ONE;
                end
            end
        end else begin
            half_cnt <= half_cnt;
        end
    end

endmodule
